// File: rtl/bin2bcd_seq_ctrl_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   BCD_DIGIT_W : bits per packed BCD digit
//   ADJ_THRESH  : digit value at or above which the add-3 correction applies
//   ADJ_OFFSET  : correction added to a digit before each shift
//   state_e     : converter FSM states
package bin2bcd_seq_ctrl_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;

  localparam logic [BCD_DIGIT_W-1:0] ADJ_THRESH = 4'd5;
  localparam logic [BCD_DIGIT_W-1:0] ADJ_OFFSET = 4'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/bin2bcd_seq_ctrl_digit_adj.sv
// Double-dabble correction cell for one BCD digit: a digit of 5 or more
// gets 3 added so that the following left shift carries into the next digit.
//   din  : current digit value
//   dout : corrected digit value (4-bit result)
module bcd_digit_adj
  import bin2bcd_seq_ctrl_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  always_comb begin
    dout = din;
    if (din >= ADJ_THRESH) begin
      dout = din + ADJ_OFFSET;
    end
  end

endmodule

// File: rtl/bin2bcd_seq_ctrl.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   start   : conversion request, accepted only while idle
//   bin_in  : binary operand, captured on acceptance
//   busy    : conversion in progress
//   done    : one-cycle pulse when bcd_out/neg/ovf are updated
//   bcd_out : packed BCD result, digit 0 in bits [3:0]
//   neg     : result sign (always 0 for unsigned operation)
//   ovf     : magnitude did not fit in DIGITS digits
module bin2bcd_seq_ctrl
  import bin2bcd_seq_ctrl_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter int SIGNED = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [WIDTH-1:0]              bin_in,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                          neg,
  output logic                          ovf
);

  localparam int ACC_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   mag_q, mag_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               neg_r_q, neg_r_d;
  logic               ovf_r_q, ovf_r_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [ACC_W-1:0]   bcd_q, bcd_d;
  logic               neg_q, neg_d;
  logic               ovf_q, ovf_d;

  logic [ACC_W-1:0]   acc_adj;
  logic [ACC_W-1:0]   acc_shift;
  logic [WIDTH-1:0]   mag_shift;
  logic               carry_out;
  logic               in_neg;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (acc_q  [g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (acc_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // {accumulator, magnitude} shifted left by one after digit correction;
  // the bit leaving the top digit is the overflow indicator.
  assign acc_shift = {acc_adj[ACC_W-2:0], mag_q[WIDTH-1]};
  assign mag_shift = {mag_q[WIDTH-2:0], 1'b0};
  assign carry_out = acc_adj[ACC_W-1];
  assign in_neg    = (SIGNED != 0) && bin_in[WIDTH-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    acc_d   = acc_q;
    neg_r_d = neg_r_q;
    ovf_r_d = ovf_r_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Negating -2^(WIDTH-1) wraps to 2^(WIDTH-1), which is exact as unsigned.
          mag_d   = in_neg ? (~bin_in + WIDTH'(1)) : bin_in;
          neg_r_d = in_neg;
          acc_d   = '0;
          ovf_r_d = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d   = acc_shift;
        mag_d   = mag_shift;
        ovf_r_d = ovf_r_q | carry_out;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          bcd_d   = acc_shift;
          neg_d   = neg_r_q;
          ovf_d   = ovf_r_q | carry_out;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mag_q   <= '0;
      acc_q   <= '0;
      neg_r_q <= 1'b0;
      ovf_r_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      acc_q   <= acc_d;
      neg_r_q <= neg_r_d;
      ovf_r_q <= ovf_r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;
  assign neg     = neg_q;
  assign ovf     = ovf_q;

endmodule

// File: doc/bin2bcd_seq_ctrl.md
Name: bin2bcd_seq_ctrl

Overview:
Sequential binary-to-BCD converter for the calculator display path. It accepts one binary result per start pulse and runs the shift-and-add-3 (double-dabble) algorithm one bit per clock. It uses per-digit add-3 adjust cells and reports the packed BCD digits plus sign and overflow flags. It sits between the ALU result register and the 7-segment digit decoders.

Parameters:
WIDTH, 8, binary input width in bits (range 4..16).
DIGITS, 3, number of BCD output digits.
SIGNED, 1, 1 = bin_in is two's complement and magnitude is converted; 0 = bin_in is unsigned.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  conversion request, sampled on the rising edge of clk.
bin_in  input  WIDTH  binary value, captured when start is accepted.
busy  output  1  high while a conversion is in progress.
done  output  1  one-cycle pulse marking that bcd_out, neg and ovf are updated.
bcd_out  output  4*DIGITS  packed BCD; digit 0 in bits [3:0].
neg  output  1  result sign (always 0 when SIGNED=0).
ovf  output  1  result did not fit in DIGITS digits.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, bcd_out=0, neg=0, ovf=0; bit counter and shift registers cleared.
- Releasing rst_n in the middle of a conversion leaves the block in IDLE with no done pulse; the aborted conversion is discarded.
- The FSM has two states: IDLE and SHIFT.
- IDLE: if start=1, capture the operand and go to SHIFT with busy=1.
  - Operand capture: mag = (SIGNED and bin_in[WIDTH-1]) ? -bin_in : bin_in, taken as WIDTH-bit unsigned. -2^(WIDTH-1) maps to 2^(WIDTH-1) without loss.
  - Also capture neg_r = SIGNED and bin_in[WIDTH-1]; clear the BCD accumulator and ovf_r; set count=0.
- SHIFT, one iteration per clock:
  - Each digit with value >=5 gets +3 (4-bit result).
  - Then shift {accumulator, mag} left by 1.
  - If the bit shifted out of the top digit is 1, set the sticky ovf_r.
  - count increments. When count reaches WIDTH-1 on this edge, the block registers bcd_out, neg and ovf, drives done=1 for the next cycle, sets busy=0 and returns to IDLE.
- Latency: start accepted at edge E0. Iterations happen at edges E1..EWIDTH. done=1 and the outputs are valid in the cycle after EWIDTH. busy=1 from E0 through EWIDTH.
- Throughput: start is accepted in the same cycle that done is high, giving back-to-back conversions every WIDTH+1 cycles.
- start while busy=1 is ignored (no queueing) and has no effect on the conversion in progress.
- bcd_out, neg and ovf hold their values until the next done; they do not change while busy.
- When ovf=1, bcd_out holds the low DIGITS digits of the true value.
- Zero input gives bcd_out=0 and neg=0 (no negative zero).

Decomposition:
- Shared calc package holds:
  - BCD_DIGIT_W=4.
  - Adjust threshold 4'd5 and offset 4'd3.
  - FSM state encodings: IDLE=1'b0, SHIFT=1'b1.
- One sub-module, bcd_digit_adj: purely combinational 4-bit "if >=5 add 3" cell, instantiated DIGITS times via generate.
- The FSM, counter and shift register stay in the top module.

Test Plan:
- WIDTH=8, SIGNED=0, start with bin_in=8'd255 -> busy high 8 cycles; done pulse in cycle 9 after start edge; bcd_out=12'h255, neg=0, ovf=0.
- SIGNED=1, bin_in=8'h80 (-128) -> bcd_out=12'h128, neg=1. Then bin_in=8'hF6 (-10) -> bcd_out=12'h010, neg=1. Then bin_in=0 -> 12'h000, neg=0.
- start=1 held every cycle with bin_in changing from 8'd42 to 8'd99 one cycle after acceptance -> result 12'h042. Next acceptance is in the done cycle, giving 12'h099 nine cycles later; exactly one done pulse per conversion.
- DIGITS=2, SIGNED=0, bin_in=8'd200 -> ovf=1, bcd_out=8'h00. Then bin_in=8'd99 -> ovf=0, bcd_out=8'h99 (ovf cleared per conversion).
- Assert rst_n low 4 cycles into a conversion of 8'd77 -> all outputs 0 immediately (asynchronous), no done after release. A fresh start with 8'd77 gives 12'h077.
- Exhaustive sweep of all 256 inputs for SIGNED=0 and SIGNED=1 against a reference model -> bcd_out, neg and ovf match for every value; done count equals start-acceptance count.
